// File: rtl/alu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_if
//  Brief    : Decoder handshake, external ALU, status and debug bundle for alu_ctrl.
//  Revision : 1.0
// ============================================================================
interface alu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_rdest;
    logic [3:0]  in_rsrc;
    logic [15:0] in_imm;
    logic        in_imm_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic        done;
    logic        illegal;
    logic [15:0] result;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    // Environment side: instruction source, external ALU and debug reader.
    modport master (
        output in_valid, in_op, in_rdest, in_rsrc, in_imm, in_imm_sel,
        input  in_ready,
        input  alu_a, alu_b, alu_op, alu_cin,
        output alu_c, alu_flags,
        input  done, illegal, result, psr,
        output dbg_addr,
        input  dbg_data
    );

    // Controller side.
    modport slave (
        input  in_valid, in_op, in_rdest, in_rsrc, in_imm, in_imm_sel,
        output in_ready,
        output alu_a, alu_b, alu_op, alu_cin,
        input  alu_c, alu_flags,
        output done, illegal, result, psr,
        input  dbg_addr,
        output dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl
//  Brief    : 4-state sequencer driving an external 16-bit ALU, 16x16 regfile, 5-bit PSR.
//             Define ALU_CTRL_B2B_EN to accept a new instruction during WB.
//  Revision : 1.0
// ============================================================================
module alu_ctrl (
    input  logic       clk,
    input  logic       reset,
    alu_ctrl_if.slave  bus
);
    localparam logic [3:0] C_OP_AND  = 4'b0001;
    localparam logic [3:0] C_OP_OR   = 4'b0010;
    localparam logic [3:0] C_OP_XOR  = 4'b0011;
    localparam logic [3:0] C_OP_ADD  = 4'b0101;
    localparam logic [3:0] C_OP_ADDU = 4'b0110;
    localparam logic [3:0] C_OP_ADDC = 4'b0111;
    localparam logic [3:0] C_OP_SUB  = 4'b1001;
    localparam logic [3:0] C_OP_SUBC = 4'b1010;
    localparam logic [3:0] C_OP_CMP  = 4'b1011;
    localparam logic [3:0] C_OP_MOV  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_legal;
    logic        w_psr_en;
    logic        w_wr_en;
    logic        w_exec;

    logic [3:0]  r_op;
    logic [3:0]  r_rdest;
    logic [3:0]  r_rsrc;
    logic [15:0] r_imm;
    logic        r_imm_sel;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_res;
    logic [4:0]  r_flg;
    logic [4:0]  r_psr;
    logic [15:0] r_result;
    logic [15:0] r_rf [16];

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            S_WB: begin
`ifdef ALU_CTRL_B2B_EN
                w_in_ready  = 1'b1;
                w_state_nxt = bus.in_valid ? S_READ : S_IDLE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_exec   = (r_state == S_EXEC);

    always_comb begin
        w_legal  = 1'b0;
        w_psr_en = 1'b0;
        case (r_op)
            C_OP_AND, C_OP_OR, C_OP_XOR, C_OP_ADDU, C_OP_MOV: w_legal = 1'b1;
            C_OP_ADD, C_OP_ADDC, C_OP_SUB, C_OP_SUBC, C_OP_CMP: begin
                w_legal  = 1'b1;
                w_psr_en = 1'b1;
            end
            default: begin
                w_legal  = 1'b0;
                w_psr_en = 1'b0;
            end
        endcase
    end

    // CMP only updates flags; its difference is discarded.
    assign w_wr_en = w_legal && (r_op != C_OP_CMP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_rdest   <= '0;
            r_rsrc    <= '0;
            r_imm     <= '0;
            r_imm_sel <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_flg     <= '0;
            r_psr     <= '0;
            r_result  <= '0;
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op      <= bus.in_op;
                r_rdest   <= bus.in_rdest;
                r_rsrc    <= bus.in_rsrc;
                r_imm     <= bus.in_imm;
                r_imm_sel <= bus.in_imm_sel;
            end
            if (r_state == S_READ) begin
                r_a <= r_rf[r_rdest];
                r_b <= r_imm_sel ? r_imm : r_rf[r_rsrc];
            end
            if (w_exec) begin
                r_res <= (r_op == C_OP_MOV) ? r_b : bus.alu_c;
                r_flg <= bus.alu_flags;
            end
            if (r_state == S_WB) begin
                if (w_wr_en) begin
                    r_rf[r_rdest] <= r_res;
                    r_result      <= r_res;
                end
                if (w_psr_en) begin
                    r_psr <= r_flg;
                end
            end
        end
    end

    // The ALU is only presented with operands while executing.
    assign bus.alu_a    = w_exec ? r_a      : 16'h0000;
    assign bus.alu_b    = w_exec ? r_b      : 16'h0000;
    assign bus.alu_op   = w_exec ? r_op     : 4'b0000;
    assign bus.alu_cin  = w_exec ? r_psr[3] : 1'b0;

    assign bus.in_ready = w_in_ready;
    assign bus.done     = (r_state == S_WB);
    assign bus.illegal  = (r_state == S_WB) && !w_legal;
    assign bus.result   = r_result;
    assign bus.psr      = r_psr;
    assign bus.dbg_data = r_rf[bus.dbg_addr];
endmodule
`default_nettype wire
